// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage enables/flushes from load-use, mispredict and dmem handshake.
// Optional perf counters (stall_cycles_o, flush_count_o) are built when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_rd_wren_i,
  input  logic        ex_is_load_i,
  input  logic        ex_mispred_i,
  input  logic        mem_op_i,
  input  logic        dmem_ack_i,
  output logic        dmem_req_o,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        id_ex_en_o,
  output logic        ex_mem_en_o,
  output logic        mem_wb_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        mem_wb_flush_o,
  output logic        fault_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CMP_W  = WAIT_W + 1;
  localparam int unsigned PERF_W = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                ack_c;
  logic                load_use_c;
  logic                wait_expired_c;
  logic                mispred_flush_c;

  // An ack only counts while a request is actually outstanding
  assign ack_c = mem_op_i & dmem_ack_i;

  assign load_use_c = ex_is_load_i & ex_rd_wren_i & (ex_rd_addr_i != 5'd0) &
                      ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                       (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));

  assign wait_expired_c = (CMP_W'(wait_cnt_q) + CMP_W'(1)) >= CMP_W'(MEM_TIMEOUT);

  // State and wait counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state and Mealy control outputs
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    dmem_req_o      = 1'b0;
    pc_en_o         = 1'b1;
    if_id_en_o      = 1'b1;
    id_ex_en_o      = 1'b1;
    ex_mem_en_o     = 1'b1;
    mem_wb_en_o     = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    mem_wb_flush_o  = 1'b0;
    fault_o         = (state_q == FAULT);
    mispred_flush_c = 1'b0;

    if (rst_i) begin
      state_d        = RUN;
      wait_cnt_d     = '0;
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_en_o    = 1'b0;
      mem_wb_en_o    = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_flush_o  = 1'b1;
      mem_wb_flush_o = 1'b1;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          dmem_req_o = mem_op_i;
          if ((state_q == RUN && mem_op_i && !dmem_ack_i) ||
              (state_q == MEM_WAIT && !ack_c)) begin
            // Hold everything up to EX/MEM; MEM/WB takes a bubble
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_en_o    = 1'b0;
            mem_wb_flush_o = 1'b1;
            if (state_q == RUN) begin
              state_d    = MEM_WAIT;
              wait_cnt_d = '0;
            end else begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
              if (wait_expired_c) begin
                state_d = FAULT;
              end
            end
          end else begin
            state_d    = RUN;
            wait_cnt_d = '0;
            // Mispredict wins: the ID instruction is wrong-path anyway
            if (ex_mispred_i) begin
              if_id_flush_o   = 1'b1;
              id_ex_flush_o   = 1'b1;
              mispred_flush_c = 1'b1;
            end else if (load_use_c) begin
              pc_en_o       = 1'b0;
              if_id_en_o    = 1'b0;
              id_ex_flush_o = 1'b1;
            end
          end
        end
        FAULT: begin
          pc_en_o     = 1'b0;
          if_id_en_o  = 1'b0;
          id_ex_en_o  = 1'b0;
          ex_mem_en_o = 1'b0;
          mem_wb_en_o = 1'b0;
        end
        default: begin
          state_d     = RUN;
          wait_cnt_d  = '0;
          pc_en_o     = 1'b0;
          if_id_en_o  = 1'b0;
          id_ex_en_o  = 1'b0;
          ex_mem_en_o = 1'b0;
          mem_wb_en_o = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] stall_cycles_q;
  logic [PERF_W-1:0] flush_count_q;

  // Free-running wrap-around performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!pc_en_o) begin
        stall_cycles_q <= stall_cycles_q + PERF_W'(1);
      end
      if (mispred_flush_c) begin
        flush_count_q <= flush_count_q + PERF_W'(1);
      end
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  logic unused_perf_c;

  assign unused_perf_c  = mispred_flush_c;
  assign stall_cycles_o = PERF_W'(0);
  assign flush_count_o  = PERF_W'(0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed test-plan scenarios plus random stimulus.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TMO = 4;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       wren;
    logic       is_load;
    logic       mispred;
    logic       mem_op;
    logic       ack;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [9:0]  ctrl;
    logic [31:0] stalls;
    logic [31:0] flushes;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [4:0]  id_rs1_addr_i = '0, id_rs2_addr_i = '0, ex_rd_addr_i = '0;
  logic        id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
  logic        ex_rd_wren_i = 1'b0, ex_is_load_i = 1'b0, ex_mispred_i = 1'b0;
  logic        mem_op_i = 1'b0, dmem_ack_i = 1'b0;
  logic        dmem_req_o, pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
  logic        if_id_flush_o, id_ex_flush_o, mem_wb_flush_o, fault_o;
  logic [31:0] stall_cycles_o, flush_count_o;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_wren_i(ex_rd_wren_i),
    .ex_is_load_i(ex_is_load_i), .ex_mispred_i(ex_mispred_i),
    .mem_op_i(mem_op_i), .dmem_ack_i(dmem_ack_i), .dmem_req_o(dmem_req_o),
    .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .id_ex_en_o(id_ex_en_o),
    .ex_mem_en_o(ex_mem_en_o), .mem_wb_en_o(mem_wb_en_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
    .mem_wb_flush_o(mem_wb_flush_o), .fault_o(fault_o),
    .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
  );

  always #5 clk_i = ~clk_i;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  // Reference model: pipeline situation as plain flags and counts
  bit          m_waiting = 0;
  bit          m_faulted = 0;
  int          m_waited  = 0;
  int unsigned m_stalls  = 0;
  int unsigned m_flushes = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.rs1 = '0; s.rs2 = '0; s.rs1_used = 1'b0; s.rs2_used = 1'b0;
    s.rd = '0; s.wren = 1'b0; s.is_load = 1'b0; s.mispred = 1'b0;
    s.mem_op = 1'b0; s.ack = 1'b0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst      = ($urandom_range(0, 99) < 2);
    s.rs1      = 5'($urandom_range(0, 3));
    s.rs2      = 5'($urandom_range(0, 3));
    s.rs1_used = 1'($urandom_range(0, 1));
    s.rs2_used = 1'($urandom_range(0, 1));
    s.rd       = 5'($urandom_range(0, 3));
    s.wren     = ($urandom_range(0, 3) != 0);
    s.is_load  = ($urandom_range(0, 1) != 0);
    s.mispred  = ($urandom_range(0, 99) < 15);
    s.mem_op   = ($urandom_range(0, 99) < 30);
    s.ack      = ($urandom_range(0, 1) != 0);
    return s;
  endfunction

  // Drive one cycle of stimulus, push the expected response, advance the model
  task automatic step(input stim_t s, input bit chk);
    exp_t e;
    bit   req, pc, ifid, idex, exmem, memwb, f_ifid, f_idex, f_memwb;
    bit   lu, got_ack, stall;
    @(negedge clk_i);
    rst_i = s.rst; id_rs1_addr_i = s.rs1; id_rs2_addr_i = s.rs2;
    id_rs1_used_i = s.rs1_used; id_rs2_used_i = s.rs2_used;
    ex_rd_addr_i = s.rd; ex_rd_wren_i = s.wren; ex_is_load_i = s.is_load;
    ex_mispred_i = s.mispred; mem_op_i = s.mem_op; dmem_ack_i = s.ack;

    lu = s.is_load && s.wren && (s.rd != 5'd0) &&
         ((s.rs1_used && s.rs1 == s.rd) || (s.rs2_used && s.rs2 == s.rd));
    got_ack = s.mem_op && s.ack;
    stall   = !got_ack && (m_waiting || s.mem_op);
    req = 0; pc = 1; ifid = 1; idex = 1; exmem = 1; memwb = 1;
    f_ifid = 0; f_idex = 0; f_memwb = 0;
    if (s.rst) begin
      {pc, ifid, idex, exmem, memwb} = '0;
      {f_ifid, f_idex, f_memwb} = '1;
    end else if (m_faulted) begin
      {pc, ifid, idex, exmem, memwb} = '0;
    end else begin
      req = s.mem_op;
      if (stall) begin
        {pc, ifid, idex, exmem} = '0;
        f_memwb = 1;
      end else if (s.mispred) begin
        f_ifid = 1; f_idex = 1;
      end else if (lu) begin
        pc = 0; ifid = 0; f_idex = 1;
      end
    end

    e.cyc  = cyc;
    e.ctrl = {req, pc, ifid, idex, exmem, memwb, f_ifid, f_idex, f_memwb, m_faulted};
`ifdef PIPE_PERF_EN
    e.stalls  = m_stalls;
    e.flushes = m_flushes;
`else
    e.stalls  = '0;
    e.flushes = '0;
`endif
    if (chk) exp_q.push_back(e);
    cyc++;

    if (s.rst) begin
      m_waiting = 0; m_faulted = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!pc) m_stalls++;
      if (!m_faulted && !stall && s.mispred) m_flushes++;
      if (m_faulted) begin
      end else if (stall && !m_waiting) begin
        m_waiting = 1; m_waited = 0;
      end else if (stall) begin
        m_waited++;
        if (m_waited >= TMO) begin
          m_faulted = 1; m_waiting = 0;
        end
      end else begin
        m_waiting = 0; m_waited = 0;
      end
    end
  endtask

  // Monitor: one DUT response per cycle, compared mid-cycle
  always begin
    exp_t e;
    logic [9:0] act;
    @(negedge clk_i);
    #2;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {dmem_req_o, pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
             if_id_flush_o, id_ex_flush_o, mem_wb_flush_o, fault_o};
      checks++;
      if (act !== e.ctrl) begin
        failures++;
        $display("FAIL ctrl cyc=%0d got=%b want=%b (req,pc,ifid,idex,exmem,memwb,fl_ifid,fl_idex,fl_memwb,fault)",
                 e.cyc, act, e.ctrl);
      end
      checks++;
      if (stall_cycles_o !== e.stalls || flush_count_o !== e.flushes) begin
        failures++;
        $display("FAIL perf cyc=%0d got stalls=%0d flushes=%0d want stalls=%0d flushes=%0d",
                 e.cyc, stall_cycles_o, flush_count_o, e.stalls, e.flushes);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle(); s.rst = 1'b1;
    step(s, 1'b0);
    step(s, 1'b1);
    step(s, 1'b1);

    // Load-use on x5, then the same with rd = x0
    s = idle(); s.rs1 = 5'd5; s.rs1_used = 1'b1; s.rd = 5'd5; s.wren = 1'b1; s.is_load = 1'b1;
    step(s, 1'b1);
    step(idle(), 1'b1);
    s.rd = 5'd0; s.rs1 = 5'd0;
    step(s, 1'b1);
    s = idle(); s.rs2 = 5'd7; s.rs2_used = 1'b1; s.rd = 5'd7; s.wren = 1'b1; s.is_load = 1'b1;
    step(s, 1'b1);

    // Mispredict with concurrent load-use
    s.mispred = 1'b1;
    step(s, 1'b1);

    // Memory op acked after 3 stall cycles
    s = idle(); s.mem_op = 1'b1;
    repeat (3) step(s, 1'b1);
    s.ack = 1'b1;
    step(s, 1'b1);
    step(idle(), 1'b1);

    // Same-cycle ack: no stall
    s = idle(); s.mem_op = 1'b1; s.ack = 1'b1;
    step(s, 1'b1);

    // Mispredict held during the wait, flushes only on the ack cycle
    s = idle(); s.mem_op = 1'b1; s.mispred = 1'b1;
    repeat (3) step(s, 1'b1);
    s.ack = 1'b1;
    step(s, 1'b1);

    // Ack with no memory op is ignored
    s = idle(); s.ack = 1'b1;
    step(s, 1'b1);

    // Timeout into FAULT, stuck until reset
    s = idle(); s.mem_op = 1'b1;
    repeat (TMO + 4) step(s, 1'b1);
    s.ack = 1'b1; s.mispred = 1'b1;
    step(s, 1'b1);
    s = idle(); s.rst = 1'b1;
    step(s, 1'b1);
    step(idle(), 1'b1);

    // Reset pulsed in the middle of a wait
    s = idle(); s.mem_op = 1'b1;
    repeat (2) step(s, 1'b1);
    s.rst = 1'b1;
    step(s, 1'b1);
    s.rst = 1'b0; s.ack = 1'b1;
    step(s, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(rand_stim(), 1'b1);
    end

    repeat (3) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the five-stage RISC-V core. Generates per-stage enable and flush strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three hazard sources: load-use dependencies, branch/jump mispredictions resolved in EX, and a data-memory request/acknowledge handshake for the instruction held in EX/MEM. Contains a three-state memory-wait FSM with a timeout watchdog.

## Interface
- MEM_TIMEOUT, 255: maximum wait cycles for dmem_ack_i before entering FAULT; legal range 1..255.
- clk_i  in  1  core clock
- rst_i  in  1  synchronous reset, active-high
- id_rs1_addr_i / id_rs2_addr_i  in  5  source registers of the instruction in ID
- id_rs1_used_i / id_rs2_used_i  in  1  instruction in ID reads rs1 / rs2
- ex_rd_addr_i  in  5  destination register of the instruction in EX
- ex_rd_wren_i  in  1  instruction in EX writes rd
- ex_is_load_i  in  1  instruction in EX is a load
- ex_mispred_i  in  1  branch/jump in EX resolved against the prediction
- mem_op_i  in  1  EX/MEM holds a load or store (is_load_o | mem_wren_o)
- dmem_ack_i  in  1  data memory completes the current access
- dmem_req_o  out  1  data-memory request
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  stage load enables
- if_id_flush_o, id_ex_flush_o, mem_wb_flush_o  out  1 each  stage loads a bubble at the next edge
- fault_o  out  1  memory timeout, sticky until reset
- stall_cycles_o  out  32  cycles with pc_en_o low (perf, see Configuration)
- flush_count_o  out  32  number of misprediction flushes (perf)

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. Reset state RUN; wait counter 0; fault_o 0.
- While rst_i high: all enables 0, all flushes 1, dmem_req_o 0.
- dmem_req_o = mem_op_i in RUN and MEM_WAIT; 0 in FAULT.
- Memory stall (highest priority): RUN with mem_op_i=1 and dmem_ack_i=0, or MEM_WAIT with dmem_ack_i=0 -> pc/if_id/id_ex/ex_mem enables 0, mem_wb_flush_o=1, all other flushes 0. RUN -> MEM_WAIT on the first such cycle.
- MEM_WAIT with dmem_ack_i=1 -> behaves as RUN this cycle (normal advance, hazard rules below apply); next state RUN; counter cleared.
- Wait counter increments each MEM_WAIT cycle without ack; reaching MEM_TIMEOUT -> FAULT.
- FAULT: all enables 0, all flushes 0, fault_o 1; exits only on reset.
- Load-use (no memory stall): ex_is_load_i & ex_rd_wren_i & ex_rd_addr_i!=0 & ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd)) -> pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; ex_mem and mem_wb advance.
- Mispredict (no memory stall): ex_mispred_i -> if_id_flush_o=1, id_ex_flush_o=1, all enables 1. Overrides load-use in the same cycle (ID instruction is wrong-path).
- Otherwise all enables 1, all flushes 0.
- Flush takes precedence over enable for the same register.

## Timing
- All control outputs combinational from state and inputs (Mealy); zero-cycle latency from hazard inputs.
- State, wait counter, fault flag and perf counters update on the rising edge of clk_i.
- dmem_ack_i sampled only while dmem_req_o=1; ack with mem_op_i=0 ignored.
- Ack in the same cycle as the request: no stall, FSM stays RUN.
- Mispredict or load-use during a memory stall is suppressed, re-evaluated when the stall releases (EX contents held).
- Reset mid-MEM_WAIT or in FAULT: RUN next cycle, counters cleared.

## Configuration
- PIPE_PERF_EN defined: stall_cycles_o counts every non-reset cycle with pc_en_o=0 (including FAULT); flush_count_o counts cycles with if_id_flush_o=1 due to mispredict; both 32-bit, wrap, cleared by reset.
- PIPE_PERF_EN undefined: no counter registers; both outputs constant 0.

## Test plan
- ID reads x5 (rs1_used=1), EX is load writing x5 -> pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1 for exactly one cycle; same with rd=x0 -> no stall.
- ex_mispred_i=1 with concurrent load-use match -> if_id_flush=1, id_ex_flush=1, pc_en=1, flush_count +1.
- mem_op_i=1, ack after 3 cycles -> 3 cycles with ex_mem_en=0 and mem_wb_flush=1, state MEM_WAIT, release on ack cycle, stall_cycles=3.
- mem_op_i=1, ack never, MEM_TIMEOUT=4 -> FAULT after 4 MEM_WAIT cycles, fault_o=1, dmem_req_o=0, enables 0 until rst_i.
- Mispredict asserted during MEM_WAIT -> no flush until ack cycle, then flush asserted that cycle.
- rst_i pulsed in MEM_WAIT -> next cycle RUN, counters 0, fault_o 0.
